if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_if.sv | 24 ++
 rtl/if_stage.sv | 201 ++++++++++++++++++++
 tb/tb_if_stage.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// SRAM-like instruction fetch bus between the IF stage and instruction memory.
interface if_stage_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding fetch FSM over an SRAM-like bus,
// IF/ID register with stall/flush, branch redirect and delay-slot tracking,
// and AdEL generation for misaligned fetch addresses.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jrpc,
  input  logic [31:0] jpc,
  input  logic        next_is_delayslot,
  if_stage_if.master  bus,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_bd,
  output logic        o_valid,
  output logic [31:0] o_except
);

  localparam logic [31:0] ADEL_CODE = 32'h0000_0010;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DISCARD} state_t;

  state_t      state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [31:0] flush_tgt, flush_tgt_n;
  logic        flush_pend, flush_pend_n;
  logic [31:0] redir_pc;
  logic        redir_v;
  logic        bd_pend;
  logic [31:0] hold_inst;
  logic        hold_adel;

  logic [31:0] target, next_pc, dlv_inst, cap_inst;
  logic        consume, redir_now, bd_now, unaligned;
  logic        deliver, dlv_adel, capture, cap_adel;

  // ID takes the current IF/ID contents on this edge
  assign consume   = o_valid & ~stall & ~flush;
  assign redir_now = consume & (pcsource != 2'b00);
  assign bd_now    = bd_pend | (consume & next_is_delayslot);
  assign unaligned = fetch_pc[1:0] != 2'b00;

  // Redirect target selected by ID
  always_comb begin
    target = bpc;
    case (pcsource)
      2'b10:   target = jrpc;
      2'b11:   target = jpc;
      default: target = bpc;
    endcase
  end

  // Same-edge redirect wins over a stored one, otherwise fall through
  assign next_pc = redir_now ? target : (redir_v ? redir_pc : fetch_pc + 32'd4);

  // Address comes straight from a register; request is masked in reset
  assign bus.inst_req  = reset & (state == S_REQ) & ~unaligned;
  assign bus.inst_addr = fetch_pc;

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_REQ;
    else        state <= state_n;
  end

  // Next-state, fetch PC, delivery and hold-capture decisions
  always_comb begin
    state_n      = state;
    fetch_pc_n   = fetch_pc;
    flush_pend_n = flush_pend;
    flush_tgt_n  = flush_tgt;
    deliver      = 1'b0;
    dlv_inst     = bus.inst_rdata;
    dlv_adel     = 1'b0;
    capture      = 1'b0;
    cap_inst     = bus.inst_rdata;
    cap_adel     = 1'b0;
    case (state)
      S_REQ: begin
        if (unaligned) begin
          // Misaligned fetch never reaches the bus; it becomes an AdEL slot
          if (flush) begin
            fetch_pc_n = flush_pc;
          end else if (stall) begin
            state_n  = S_HOLD;
            capture  = 1'b1;
            cap_inst = 32'd0;
            cap_adel = 1'b1;
          end else begin
            deliver    = 1'b1;
            dlv_inst   = 32'd0;
            dlv_adel   = 1'b1;
            fetch_pc_n = next_pc;
          end
        end else if (bus.inst_addr_ok) begin
          if (flush) begin
            state_n      = S_DISCARD;
            fetch_pc_n   = flush_pc;
            flush_pend_n = 1'b0;
          end else if (flush_pend) begin
            state_n      = S_DISCARD;
            fetch_pc_n   = flush_tgt;
            flush_pend_n = 1'b0;
          end else begin
            state_n = S_WAIT;
          end
        end else if (flush) begin
          // Address must stay stable until accepted; remember the target
          flush_pend_n = 1'b1;
          flush_tgt_n  = flush_pc;
        end
      end
      S_WAIT: begin
        if (flush) begin
          fetch_pc_n = flush_pc;
          state_n    = bus.inst_data_ok ? S_REQ : S_DISCARD;
        end else if (bus.inst_data_ok) begin
          if (stall) begin
            state_n = S_HOLD;
            capture = 1'b1;
          end else begin
            state_n    = S_REQ;
            deliver    = 1'b1;
            fetch_pc_n = next_pc;
          end
        end
      end
      S_HOLD: begin
        if (flush) begin
          state_n    = S_REQ;
          fetch_pc_n = flush_pc;
        end else if (!stall) begin
          state_n    = S_REQ;
          deliver    = 1'b1;
          dlv_inst   = hold_inst;
          dlv_adel   = hold_adel;
          fetch_pc_n = next_pc;
        end
      end
      S_DISCARD: begin
        if (flush)            fetch_pc_n = flush_pc;
        if (bus.inst_data_ok) state_n    = S_REQ;
      end
      default: state_n = S_REQ;
    endcase
  end

  // Control state and the IF/ID register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc   <= RESET_PC;
      flush_pend <= 1'b0;
      redir_v    <= 1'b0;
      bd_pend    <= 1'b0;
      o_valid    <= 1'b0;
      o_inst     <= 32'd0;
      o_pc       <= 32'd0;
      o_bd       <= 1'b0;
      o_except   <= 32'd0;
    end else begin
      fetch_pc   <= fetch_pc_n;
      flush_pend <= flush_pend_n;
      if (flush) begin
        o_valid <= 1'b0;
        redir_v <= 1'b0;
        bd_pend <= 1'b0;
      end else begin
        if (deliver) begin
          o_inst   <= dlv_inst;
          o_pc     <= fetch_pc;
          o_valid  <= 1'b1;
          o_bd     <= bd_now;
          o_except <= dlv_adel ? ADEL_CODE : 32'd0;
          redir_v  <= 1'b0;
          bd_pend  <= 1'b0;
        end else begin
          if (!stall)                       o_valid <= 1'b0;
          if (redir_now)                    redir_v <= 1'b1;
          if (consume && next_is_delayslot) bd_pend <= 1'b1;
        end
      end
    end
  end

  // Data-only holding registers
  always_ff @(posedge clk) begin
    flush_tgt <= flush_tgt_n;
    if (redir_now) redir_pc <= target;
    if (capture) begin
      hold_inst <= cap_inst;
      hold_adel <= cap_adel;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: memory slave with random handshake latency,
// an ID-side driver with random stall/flush/branches, and a scoreboard that
// predicts the architectural fetch stream (pc, inst, bd, except).
module tb_if_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, flush, next_is_delayslot;
  logic [31:0] flush_pc, bpc, jrpc, jpc;
  logic [1:0]  pcsource;
  logic [31:0] o_inst, o_pc, o_except;
  logic        o_bd, o_valid;

  if_stage_if bus();

  if_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .pcsource(pcsource), .bpc(bpc), .jrpc(jrpc), .jpc(jpc),
    .next_is_delayslot(next_is_delayslot), .bus(bus),
    .o_inst(o_inst), .o_pc(o_pc), .o_bd(o_bd), .o_valid(o_valid), .o_except(o_except)
  );

  typedef struct packed { logic [31:0] pc; logic bd; } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0, n_bad = 0, ndeliv = 0, idle = 0;
  logic        mon_on = 1'b0, seen = 1'b0;
  logic [31:0] m_cur_pc = 32'd0, after_ds = 32'd0;
  logic        m_cur_bd = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: a fresh IF/ID entry appears whenever the last edge had stall=0
  logic [31:0] prev_pc, prev_inst, ei, ee;
  logic        prev_bd, prev_valid;
  exp_t        e;
  always @(negedge clk) begin
    if (mon_on) begin
      if (o_valid && !stall) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_delivery: got pc 0x%08h, expected none", o_pc);
        end else begin
          e  = exp_q.pop_front();
          ei = (e.pc[1:0] != 2'b00) ? 32'd0 : mem_word(e.pc);
          ee = (e.pc[1:0] != 2'b00) ? 32'h10 : 32'd0;
          if (o_pc !== e.pc || o_inst !== ei || o_bd !== e.bd || o_except !== ee) begin
            n_bad++;
            $display("FAIL delivery: got pc=%08h inst=%08h bd=%0b exc=%08h, expected pc=%08h inst=%08h bd=%0b exc=%08h",
                     o_pc, o_inst, o_bd, o_except, e.pc, ei, e.bd, ee);
          end
          m_cur_pc = e.pc;
          m_cur_bd = e.bd;
          ndeliv++;
          idle = 0;
        end
      end else if (seen && stall && !flush) begin
        n_cmp++;
        if ({o_valid, o_pc, o_inst, o_bd} !== {prev_valid, prev_pc, prev_inst, prev_bd}) begin
          n_bad++;
          $display("FAIL stall_hold: got v=%0b pc=%08h inst=%08h, expected v=%0b pc=%08h inst=%08h",
                   o_valid, o_pc, o_inst, prev_valid, prev_pc, prev_inst);
        end
      end
      if (exp_q.size() != 0) idle++;
      if (idle > 300) begin
        n_cmp++;
        n_bad++;
        $display("FAIL progress: got no delivery for %0d cycles, expected pc 0x%08h", idle, exp_q[0].pc);
        idle = 0;
      end
      prev_valid = o_valid;
      prev_pc    = o_pc;
      prev_inst  = o_inst;
      prev_bd    = o_bd;
      seen       = 1'b1;
    end
  end

  // Stimulus: reset, then memory slave and ID-side driver each cycle
  initial begin
    logic        pend, aok_d, dok_d, req_d, phase1, st, fl, br;
    logic [31:0] paddr, addr_d, tgt;
    int          cnt;
    pend = 1'b0; aok_d = 1'b0; dok_d = 1'b0; req_d = 1'b0;
    paddr = 32'd0; addr_d = 32'd0; cnt = 0;
    reset = 1'b0; stall = 1'b0; flush = 1'b0; flush_pc = 32'd0;
    pcsource = 2'b00; bpc = 32'd0; jrpc = 32'd0; jpc = 32'd0; next_is_delayslot = 1'b0;
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'd0;

    repeat (3) @(negedge clk);
    check("rst_inst_req", {31'd0, bus.inst_req}, 32'd0);
    check("rst_inst_addr", bus.inst_addr, 32'hBFC0_0000);
    check("rst_o_valid", {31'd0, o_valid}, 32'd0);
    check("rst_o_inst", o_inst, 32'd0);
    check("rst_o_pc", o_pc, 32'd0);
    check("rst_o_bd", {31'd0, o_bd}, 32'd0);
    check("rst_o_except", o_except, 32'd0);

    reset = 1'b1;
    @(negedge clk);
    check("first_inst_req", {31'd0, bus.inst_req}, 32'd1);
    check("first_inst_addr", bus.inst_addr, 32'hBFC0_0000);
    exp_q.push_back(exp_t'{pc: 32'hBFC0_0000, bd: 1'b0});
    mon_on = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      #1;
      phase1 = (cyc < 40);

      // Memory slave: account for the edge just passed, then drive the next one
      if (dok_d) pend = 1'b0;
      if (aok_d && req_d) begin
        check("accept_aligned", {30'd0, addr_d[1:0]}, 32'd0);
        check("one_outstanding", {31'd0, pend}, 32'd0);
        pend  = 1'b1;
        paddr = addr_d;
        cnt   = phase1 ? 0 : int'($urandom_range(0, 3));
      end
      aok_d = phase1 ? 1'b1 : ($urandom_range(0, 9) < 7);
      req_d  = bus.inst_req;
      addr_d = bus.inst_addr;
      if (pend && cnt == 0) begin
        dok_d = 1'b1;
        bus.inst_rdata = mem_word(paddr);
      end else begin
        dok_d = 1'b0;
        if (pend) cnt--;
        bus.inst_rdata = $urandom;
      end
      bus.inst_addr_ok = aok_d;
      bus.inst_data_ok = dok_d;

      // ID side: random stall/flush, branches only from non-delay-slot entries
      st  = !phase1 && ($urandom_range(0, 2) == 0);
      fl  = !phase1 && ($urandom_range(0, 24) == 0);
      br  = !phase1 && !m_cur_bd && ($urandom_range(0, 2) == 0);
      tgt = 32'hBFC0_0000 + ($urandom_range(0, 255) << 2) + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
      bpc = $urandom; jrpc = $urandom; jpc = $urandom;
      if (o_valid) begin
        pcsource = br ? 2'($urandom_range(1, 3)) : 2'b00;
        case (pcsource)
          2'b01:   bpc  = tgt;
          2'b10:   jrpc = tgt;
          2'b11:   jpc  = tgt;
          default: ;
        endcase
        next_is_delayslot = br;
      end else begin
        pcsource          = 2'($urandom_range(0, 3));
        next_is_delayslot = 1'($urandom_range(0, 1));
      end
      flush_pc = 32'hBFC0_0380 + ($urandom_range(0, 63) << 2);
      stall    = st;
      flush    = fl;

      // Reference model: successor of the consumed instruction, or flush target
      if (fl) begin
        exp_q.delete();
        exp_q.push_back(exp_t'{pc: flush_pc, bd: 1'b0});
      end else if (o_valid && !st) begin
        if (br) begin
          exp_q.push_back(exp_t'{pc: m_cur_pc + 32'd4, bd: 1'b1});
          after_ds = tgt;
        end else if (m_cur_bd) begin
          exp_q.push_back(exp_t'{pc: after_ds, bd: 1'b0});
        end else begin
          exp_q.push_back(exp_t'{pc: m_cur_pc + 32'd4, bd: 1'b0});
        end
      end

      if (cyc == 39) begin
        n_cmp++;
        if (ndeliv < 12) begin
          n_bad++;
          $display("FAIL throughput: got %0d deliveries in 40 cycles, expected at least 12", ndeliv);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
